servo_pwm_driver: RTL and testbench

Converts the filtered roll and pitch angles from the MPU controller into two hobby-servo PWM signals for the gimbal servos. The block samples the signed-degree angles once per PWM frame, clamps them to the servo travel limit and optionally slew-limits them. It then generates glitch-free pulses whose width changes only on frame boundaries. It sits directly downstream of the MPU controller's `roll`/`pitch` outputs and drives FPGA output pins.

---
 rtl/servo_pwm_driver.sv | 132 +++++++++++++
 tb/tb_servo_pwm_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: two-channel hobby-servo PWM generator for the gimbal.
// Samples the signed roll/pitch angles once per frame, clamps them to the
// travel limit and produces pulses whose width changes only between frames.
// Optional feature macro: SERVO_SLEW_EN limits the per-frame change of the
// commanded angle to MAX_STEP_DEG.
module servo_pwm_driver #(
    parameter int FRAME_CYCLES  = 2_000_000,
    parameter int CENTER_CYCLES = 150_000,
    parameter int STEP_CYCLES   = 1_111,
    parameter int LIMIT_DEG     = 90,
    parameter int MAX_STEP_DEG  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] roll,
    input  logic [9:0] pitch,
    output logic       pwm_roll,
    output logic       pwm_pitch,
    output logic       frame_start,
    output logic [9:0] cmd_roll,
    output logic [9:0] cmd_pitch,
    output logic [1:0] clamped
);

    localparam logic signed [9:0] LIM_P = 10'(LIMIT_DEG);
    localparam logic signed [9:0] LIM_N = -LIM_P;

    // Reject parameter sets where the widest pulse would not fit in a frame.
    if (FRAME_CYCLES <= CENTER_CYCLES + LIMIT_DEG * STEP_CYCLES + 2 || MAX_STEP_DEG < 1) begin : g_bad_params
        $error("servo_pwm_driver: illegal parameter combination");
    end

    logic [21:0]        cnt, cnt_nxt;
    logic               en_q, en_nxt;
    logic               is_sample, is_update;
    logic signed [9:0]  tgt_roll, tgt_pitch;
    logic signed [9:0]  cmd_r, cmd_p, cmd_r_nxt, cmd_p_nxt;
    logic [21:0]        pulse_roll, pulse_pitch, pulse_roll_nxt, pulse_pitch_nxt;
    logic               roll_over, pitch_over;

    function automatic logic signed [9:0] clamp_deg(input logic signed [9:0] a);
        if (a > LIM_P)      return LIM_P;
        else if (a < LIM_N) return LIM_N;
        else                return a;
    endfunction

    function automatic logic [21:0] pulse_of(input logic signed [9:0] c);
        logic signed [31:0] w;
        w = CENTER_CYCLES + 32'(c) * STEP_CYCLES;
        return 22'(w);
    endfunction

`ifdef SERVO_SLEW_EN
    localparam logic signed [10:0] SLEW_MAX = 11'(MAX_STEP_DEG);
    localparam logic signed [9:0]  SLEW_STEP = 10'(MAX_STEP_DEG);

    function automatic logic signed [9:0] next_cmd(input logic signed [9:0] cur,
                                                   input logic signed [9:0] tgt);
        logic signed [10:0] diff;
        diff = $signed({tgt[9], tgt}) - $signed({cur[9], cur});
        if (diff > SLEW_MAX)       return cur + SLEW_STEP;
        else if (diff < -SLEW_MAX) return cur - SLEW_STEP;
        else                       return tgt;
    endfunction
`else
    function automatic logic signed [9:0] next_cmd(input logic signed [9:0] cur,
                                                   input logic signed [9:0] tgt);
        logic signed [9:0] unused_cur;
        unused_cur = cur;
        return (unused_cur == tgt) ? unused_cur : tgt;
    endfunction
`endif

    // Next-cycle values of counter, enable, command and pulse width; the PWM
    // register is loaded from these so the output lines up with cnt exactly.
    always_comb begin
        is_sample       = (cnt == 22'(FRAME_CYCLES - 2));
        is_update       = (cnt == 22'(FRAME_CYCLES - 1));
        cnt_nxt         = is_update ? '0 : cnt + 22'd1;
        en_nxt          = is_sample ? enable : en_q;
        roll_over       = ($signed(roll) > LIM_P) || ($signed(roll) < LIM_N);
        pitch_over      = ($signed(pitch) > LIM_P) || ($signed(pitch) < LIM_N);
        cmd_r_nxt       = cmd_r;
        cmd_p_nxt       = cmd_p;
        pulse_roll_nxt  = pulse_roll;
        pulse_pitch_nxt = pulse_pitch;
        if (is_update) begin
            cmd_r_nxt       = next_cmd(cmd_r, tgt_roll);
            cmd_p_nxt       = next_cmd(cmd_p, tgt_pitch);
            pulse_roll_nxt  = pulse_of(cmd_r_nxt);
            pulse_pitch_nxt = pulse_of(cmd_p_nxt);
        end
    end

    // Frame counter, sampled targets, per-frame command and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            en_q        <= 1'b0;
            tgt_roll    <= '0;
            tgt_pitch   <= '0;
            clamped     <= '0;
            cmd_r       <= '0;
            cmd_p       <= '0;
            pulse_roll  <= 22'(CENTER_CYCLES);
            pulse_pitch <= 22'(CENTER_CYCLES);
            pwm_roll    <= 1'b0;
            pwm_pitch   <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            cnt         <= cnt_nxt;
            en_q        <= en_nxt;
            if (is_sample) begin
                tgt_roll  <= clamp_deg($signed(roll));
                tgt_pitch <= clamp_deg($signed(pitch));
                clamped   <= {pitch_over, roll_over};
            end
            cmd_r       <= cmd_r_nxt;
            cmd_p       <= cmd_p_nxt;
            pulse_roll  <= pulse_roll_nxt;
            pulse_pitch <= pulse_pitch_nxt;
            pwm_roll    <= en_nxt && (cnt_nxt < pulse_roll_nxt);
            pwm_pitch   <= en_nxt && (cnt_nxt < pulse_pitch_nxt);
            frame_start <= (cnt_nxt == '0);
        end
    end

    assign cmd_roll  = cmd_r;
    assign cmd_pitch = cmd_p;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: scoreboard bench for servo_pwm_driver using a short
// frame so many frames fit in a run. Works with or without SERVO_SLEW_EN.
module tb_servo_pwm_driver;

    localparam int F = 500;
    localparam int C = 200;
    localparam int S = 2;
    localparam int L = 90;
    localparam int M = 5;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [9:0] roll;
    logic [9:0] pitch;
    logic       pwm_roll;
    logic       pwm_pitch;
    logic       frame_start;
    logic [9:0] cmd_roll;
    logic [9:0] cmd_pitch;
    logic [1:0] clamped;

    servo_pwm_driver #(
        .FRAME_CYCLES (F),
        .CENTER_CYCLES(C),
        .STEP_CYCLES  (S),
        .LIMIT_DEG    (L),
        .MAX_STEP_DEG (M)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .roll       (roll),
        .pitch      (pitch),
        .pwm_roll   (pwm_roll),
        .pwm_pitch  (pwm_pitch),
        .frame_start(frame_start),
        .cmd_roll   (cmd_roll),
        .cmd_pitch  (cmd_pitch),
        .clamped    (clamped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int cr;
        int cp;
        int cl;
        int wr;
        int wp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_cr  = 0;
    int   m_cp  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > L)  return L;
        if (v < -L) return -L;
        return v;
    endfunction

    function automatic int step_to(input int cur, input int tgt);
`ifdef SERVO_SLEW_EN
        if (tgt - cur > M)  return cur + M;
        if (cur - tgt > M)  return cur - M;
`endif
        return tgt;
    endfunction

    // Predict what the frame after the one whose SAMPLE sees (r, p, en) shows.
    task automatic push_model(input int r, input int p, input int en);
        exp_t e;
        int   tr, tp;
        tr   = clampv(r);
        tp   = clampv(p);
        m_cr = step_to(m_cr, tr);
        m_cp = step_to(m_cp, tp);
        e.cr = m_cr;
        e.cp = m_cp;
        e.cl = ((r != tr) ? 1 : 0) + ((p != tp) ? 2 : 0);
        e.wr = en ? C + m_cr * S : 0;
        e.wp = en ? C + m_cp * S : 0;
        sb.push_back(e);
    endtask

    task automatic push_reset();
        exp_t e;
        sb.delete();
        m_cr = 0;
        m_cp = 0;
        e.cr = 0; e.cp = 0; e.cl = 0; e.wr = 0; e.wp = 0;
        sb.push_back(e);
    endtask

    // Runs one frame from a negedge with cnt==0. roll/enable switch to r1/e1
    // at cycle chg (if >= 0); reset is asserted at cycle rst_at (if >= 0).
    task automatic run_frame(input int r0, input int p0, input int e0,
                             input int chg, input int r1, input int e1,
                             input int rst_at);
        exp_t e;
        int   wr, wp, bad, fs, rs, es;
        check("frame_start_at0", int'(frame_start), 1);
        check("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("cmd_roll", int'($signed(cmd_roll)), e.cr);
        check("cmd_pitch", int'($signed(cmd_pitch)), e.cp);
        check("clamped", int'(clamped), e.cl);
        roll   = 10'(r0);
        pitch  = 10'(p0);
        enable = e0[0];
        rs = (chg >= 0 && chg <= F - 2) ? r1 : r0;
        es = (chg >= 0 && chg <= F - 2) ? e1 : e0;
        push_model(rs, p0, es);
        wr = 0; wp = 0; bad = 0; fs = 0;
        for (int i = 0; i < F; i++) begin
            if (i > 0) @(negedge clock);
            if (i == chg) begin
                roll   = 10'(r1);
                enable = e1[0];
            end
            if (i == rst_at) begin
                check("pwm_before_reset", int'(pwm_roll), (i < e.wr) ? 1 : 0);
                reset = 1'b1;
                #1;
                check("rst_pwm_roll", int'(pwm_roll), 0);
                check("rst_pwm_pitch", int'(pwm_pitch), 0);
                check("rst_frame_start", int'(frame_start), 1);
                check("rst_cmd_roll", int'($signed(cmd_roll)), 0);
                check("rst_clamped", int'(clamped), 0);
                repeat (2) @(negedge clock);
                reset = 1'b0;
                push_reset();
                return;
            end
            wr += int'(pwm_roll);
            wp += int'(pwm_pitch);
            fs += int'(frame_start);
            if (int'(pwm_roll) != ((i < e.wr) ? 1 : 0)) bad++;
            if (int'(pwm_pitch) != ((i < e.wp) ? 1 : 0)) bad++;
        end
        check("width_roll", wr, e.wr);
        check("width_pitch", wp, e.wp);
        check("pulse_shape", bad, 0);
        check("frame_start_count", fs, 1);
        @(negedge clock);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        roll   = '0;
        pitch  = '0;
        repeat (3) @(negedge clock);
        check("reset_pwm_roll", int'(pwm_roll), 0);
        check("reset_pwm_pitch", int'(pwm_pitch), 0);
        check("reset_frame_start", int'(frame_start), 1);
        check("reset_cmd_roll", int'($signed(cmd_roll)), 0);
        check("reset_clamped", int'(clamped), 0);
        reset = 1'b0;
        push_reset();

        run_frame(0, 0, 1, -1, 0, 0, -1);       // frame 1: no pulse
        run_frame(0, 0, 1, -1, 0, 0, -1);       // centre pulses
        run_frame(90, -90, 1, -1, 0, 0, -1);    // exact limits
        run_frame(200, -512, 1, -1, 0, 0, -1);  // out of range
        run_frame(91, -91, 1, -1, 0, 0, -1);
        run_frame(89, -89, 1, -1, 0, 0, -1);
        run_frame(0, 0, 1, -1, 0, 0, -1);
        for (int k = 0; k < 6; k++)
            run_frame(30, 0, 1, -1, 0, 0, -1);  // slew ramp when enabled
        run_frame(0, 0, 1, 10, 45, 1, -1);     // change mid-pulse, before SAMPLE
        run_frame(0, 0, 1, F - 1, 45, 1, -1);  // change after SAMPLE: ignored
        run_frame(0, 0, 0, -1, 0, 0, -1);      // disabled
        run_frame(0, 0, 0, 100, 0, 1, -1);     // enable toggled mid-frame
        run_frame(-45, 45, 1, -1, 0, 0, -1);
        run_frame(0, 0, 1, -1, 0, 0, 50);      // reset mid-pulse
        run_frame(0, 0, 1, -1, 0, 0, -1);
        run_frame(0, 0, 1, -1, 0, 0, -1);
        run_frame(0, 0, 1, -1, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
